// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one sequential divider between REQUESTERS clients, one op in flight.
// Optional DIVIDER_ARBITER_ZERO_CHECK_EN: zero divisors bypass the divider and add o_div_by_zero.
module divider_arbiter #(
    parameter int N          = 4,
    parameter int REQUESTERS = 2
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [REQUESTERS-1:0]   i_request,
    input  logic [REQUESTERS*N-1:0] i_dividend,
    input  logic [REQUESTERS*N-1:0] i_divisor,
    output logic [REQUESTERS-1:0]   o_grant,
    output logic [REQUESTERS-1:0]   o_done,
    output logic [N-1:0]            o_quotient,
    output logic [N-1:0]            o_remainder,
    output logic                    o_busy,
    output logic                    o_div_start,
    output logic [N-1:0]            o_div_dividend,
    output logic [N-1:0]            o_div_divisor,
`ifdef DIVIDER_ARBITER_ZERO_CHECK_EN
    output logic                    o_div_by_zero,
`endif
    input  logic                    i_div_finished,
    input  logic [N-1:0]            i_div_quotient,
    input  logic [N-1:0]            i_div_remainder
);

    localparam int REQ_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_ARM    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [REQ_W-1:0]        last_r, last_s;
    logic [REQUESTERS-1:0]   grant_r, grant_s;
    logic [REQUESTERS-1:0]   done_r, done_s;
    logic [N-1:0]            quot_r, quot_s;
    logic [N-1:0]            rem_r, rem_s;
    logic [N-1:0]            dd_r, dd_s;
    logic [N-1:0]            ds_r, ds_s;
    logic                    busy_r, start_r;
    logic                    dbz_r, dbz_s;
    logic                    found_s;
    logic [REQ_W-1:0]        win_s, cand_s;
    logic [REQUESTERS-1:0]   win_onehot_s;
    logic [N-1:0]            sel_dd_s, sel_ds_s;

    // Round-robin search starting just after the last served client; selects its operands.
    always_comb begin
        found_s  = 1'b0;
        win_s    = last_r;
        cand_s   = last_r;
        sel_dd_s = {N{1'b0}};
        sel_ds_s = {N{1'b0}};
        for (int k = 1; k <= REQUESTERS; k++) begin
            cand_s = REQ_W'((int'(last_r) + k) % REQUESTERS);
            if (!found_s && i_request[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        for (int k = 0; k < REQUESTERS; k++) begin
            if (win_s == REQ_W'(k)) begin
                sel_dd_s = i_dividend[k*N +: N];
                sel_ds_s = i_divisor[k*N +: N];
            end else begin
                sel_dd_s = sel_dd_s;
            end
        end
        win_onehot_s = {{(REQUESTERS-1){1'b0}}, 1'b1} << win_s;
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s = state_r;
        last_s  = last_r;
        grant_s = grant_r;
        done_s  = {REQUESTERS{1'b0}};
        quot_s  = quot_r;
        rem_s   = rem_r;
        dd_s    = dd_r;
        ds_s    = ds_r;
        dbz_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    last_s  = win_s;
                    grant_s = win_onehot_s;
                    dd_s    = sel_dd_s;
                    ds_s    = sel_ds_s;
`ifdef DIVIDER_ARBITER_ZERO_CHECK_EN
                    if (sel_ds_s == {N{1'b0}}) begin
                        state_s = ST_DONE;
                        quot_s  = {N{1'b1}};
                        rem_s   = sel_dd_s;
                        done_s  = win_onehot_s;
                        dbz_s   = 1'b1;
                    end else begin
                        state_s = ST_LAUNCH;
                    end
`else
                    state_s = ST_LAUNCH;
`endif
                end else begin
                    grant_s = {REQUESTERS{1'b0}};
                end
            end
            ST_LAUNCH: state_s = ST_ARM;
            // A finished seen here belongs to the previous operation.
            ST_ARM:    state_s = ST_WAIT;
            ST_WAIT: begin
                if (i_div_finished) begin
                    quot_s  = i_div_quotient;
                    rem_s   = i_div_remainder;
                    done_s  = grant_r;
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                grant_s = {REQUESTERS{1'b0}};
                state_s = ST_IDLE;
            end
            default: begin
                grant_s = {REQUESTERS{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
            last_r  <= REQ_W'(REQUESTERS - 1);
            grant_r <= {REQUESTERS{1'b0}};
            done_r  <= {REQUESTERS{1'b0}};
            quot_r  <= {N{1'b0}};
            rem_r   <= {N{1'b0}};
            dd_r    <= {N{1'b0}};
            ds_r    <= {N{1'b0}};
            busy_r  <= 1'b0;
            start_r <= 1'b0;
            dbz_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            last_r  <= last_s;
            grant_r <= grant_s;
            done_r  <= done_s;
            quot_r  <= quot_s;
            rem_r   <= rem_s;
            dd_r    <= dd_s;
            ds_r    <= ds_s;
            busy_r  <= (state_s != ST_IDLE);
            start_r <= (state_s == ST_LAUNCH);
            dbz_r   <= dbz_s;
        end
    end

    assign o_grant        = grant_r;
    assign o_done         = done_r;
    assign o_quotient     = quot_r;
    assign o_remainder    = rem_r;
    assign o_busy         = busy_r;
    assign o_div_start    = start_r;
    assign o_div_dividend = dd_r;
    assign o_div_divisor  = ds_r;
`ifdef DIVIDER_ARBITER_ZERO_CHECK_EN
    assign o_div_by_zero  = dbz_r;
`else
    logic unused_dbz_s;
    assign unused_dbz_s   = dbz_r;
`endif

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter (N=4, two clients) with a behavioural fixed-latency divider.
module tb_divider_arbiter;

    localparam int N = 4;
    localparam int R = 2;

    logic           i_clock = 1'b0;
    logic           i_reset;
    logic [R-1:0]   i_request;
    logic [R*N-1:0] i_dividend, i_divisor;
    logic [R-1:0]   o_grant, o_done;
    logic [N-1:0]   o_quotient, o_remainder, o_div_dividend, o_div_divisor;
    logic           o_busy, o_div_start;
`ifdef DIVIDER_ARBITER_ZERO_CHECK_EN
    logic           o_div_by_zero;
`endif
    logic           i_div_finished;
    logic           fin_m, fin_x;
    logic [N-1:0]   q_m, r_m;
    logic [2:0]     cnt_m;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    int s0, d0;

    always #5 i_clock = ~i_clock;

    assign i_div_finished = fin_m | fin_x;

    divider_arbiter #(.N(N), .REQUESTERS(R)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_request(i_request),
        .i_dividend(i_dividend), .i_divisor(i_divisor),
        .o_grant(o_grant), .o_done(o_done), .o_quotient(o_quotient), .o_remainder(o_remainder),
        .o_busy(o_busy), .o_div_start(o_div_start),
        .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
`ifdef DIVIDER_ARBITER_ZERO_CHECK_EN
        .o_div_by_zero(o_div_by_zero),
`endif
        .i_div_finished(i_div_finished), .i_div_quotient(q_m), .i_div_remainder(r_m)
    );

    // Divider model: finished pulses four cycles after start, result from the latched operands.
    always @(posedge i_clock) begin
        if (i_reset) begin
            cnt_m <= 3'd0;
            fin_m <= 1'b0;
            q_m   <= 4'd0;
            r_m   <= 4'd0;
        end else begin
            fin_m <= 1'b0;
            if (o_div_start) begin
                cnt_m <= 3'd4;
            end else if (cnt_m != 3'd0) begin
                cnt_m <= cnt_m - 3'd1;
                if (cnt_m == 3'd1) begin
                    fin_m <= 1'b1;
                    if (o_div_divisor == 4'd0) begin
                        q_m <= 4'hf;
                        r_m <= o_div_dividend;
                    end else begin
                        q_m <= o_div_dividend / o_div_divisor;
                        r_m <= o_div_dividend % o_div_divisor;
                    end
                end
            end
        end
    end

    // Pulse counters for starts and dones.
    always @(posedge i_clock) begin
        if (o_div_start) start_cnt <= start_cnt + 1;
        if (o_done != 2'b00) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        if (obs !== exp_v) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge i_clock);
            n++;
        end while (o_done == 2'b00 && n < 60);
        chk({tag, "_no_timeout"}, 32'(n < 60), 32'd1);
    endtask

    task automatic set_op(input int c, input logic [N-1:0] dd, input logic [N-1:0] ds);
        i_dividend[c*N +: N] = dd;
        i_divisor[c*N +: N]  = ds;
    endtask

    task automatic do_reset();
        i_reset   = 1'b1;
        i_request = 2'b00;
        @(negedge i_clock);
        i_reset   = 1'b0;
    endtask

    initial begin
        i_reset    = 1'b1;
        i_request  = 2'b00;
        i_dividend = 8'd0;
        i_divisor  = 8'd0;
        fin_x      = 1'b0;
        repeat (2) @(negedge i_clock);
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_done",  32'(o_done),  32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_start", 32'(o_div_start), 32'd0);
        chk("rst_q",     32'(o_quotient), 32'd0);

        // Client0 alone 13/3, stale finished injected during LAUNCH and ARM.
        i_reset = 1'b0;
        set_op(0, 4'd13, 4'd3);
        i_request = 2'b01;
        s0 = start_cnt;
        @(negedge i_clock);
        chk("t1_grant", 32'(o_grant), 32'd1);
        chk("t1_start", 32'(o_div_start), 32'd1);
        chk("t1_dd",    32'(o_div_dividend), 32'd13);
        chk("t1_ds",    32'(o_div_divisor), 32'd3);
        chk("t1_busy",  32'(o_busy), 32'd1);
        fin_x = 1'b1;
        @(negedge i_clock);
        chk("t1_start_once", 32'(o_div_start), 32'd0);
        @(negedge i_clock);
        fin_x = 1'b0;
        chk("t1_stale_ignored", 32'(o_done), 32'd0);
        wait_done("t1");
        chk("t1_done", 32'(o_done), 32'd1);
        chk("t1_q",    32'(o_quotient), 32'd4);
        chk("t1_r",    32'(o_remainder), 32'd1);
        chk("t1_nstart", 32'(start_cnt - s0), 32'd1);
        i_request = 2'b00;
        @(negedge i_clock);
        chk("t1_grant_idle", 32'(o_grant), 32'd0);
        chk("t1_done_pulse", 32'(o_done), 32'd0);
        chk("t1_q_held", 32'(o_quotient), 32'd4);

        // Simultaneous requests after reset: client0 first, then client1.
        do_reset();
        set_op(0, 4'd13, 4'd3);
        set_op(1, 4'd9, 4'd2);
        i_request = 2'b11;
        wait_done("t2a");
        chk("t2a_done", 32'(o_done), 32'd1);
        chk("t2a_q", 32'(o_quotient), 32'd4);
        chk("t2a_r", 32'(o_remainder), 32'd1);
        i_request[0] = 1'b0;
        wait_done("t2b");
        chk("t2b_done", 32'(o_done), 32'd2);
        chk("t2b_q", 32'(o_quotient), 32'd4);
        chk("t2b_r", 32'(o_remainder), 32'd1);
        i_request = 2'b00;

        // Both held for four ops: strict rotation, one IDLE cycle between ops.
        do_reset();
        i_request = 2'b11;
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) begin
            wait_done("t3");
            chk("t3_order", 32'(o_done), (i % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge i_clock);
            chk("t3_idle_gap", 32'(o_busy), 32'd0);
        end
        i_request = 2'b00;
        chk("t3_nstart", 32'(start_cnt - s0), 32'd4);

        // Client1 divides by zero.
        set_op(1, 4'd7, 4'd0);
        i_request = 2'b10;
        s0 = start_cnt;
        wait_done("t4");
        chk("t4_done", 32'(o_done), 32'd2);
        chk("t4_q", 32'(o_quotient), 32'd15);
        chk("t4_r", 32'(o_remainder), 32'd7);
`ifdef DIVIDER_ARBITER_ZERO_CHECK_EN
        chk("t4_dbz", 32'(o_div_by_zero), 32'd1);
        chk("t4_nstart", 32'(start_cnt - s0), 32'd0);
`else
        chk("t4_nstart", 32'(start_cnt - s0), 32'd1);
`endif
        i_request = 2'b00;
        @(negedge i_clock);

        // Reset while waiting on the divider.
        set_op(0, 4'd13, 4'd3);
        i_request = 2'b01;
        repeat (3) @(negedge i_clock);
        chk("t5_busy_wait", 32'(o_busy), 32'd1);
        d0 = done_cnt;
        i_reset   = 1'b1;
        i_request = 2'b00;
        @(negedge i_clock);
        i_reset = 1'b0;
        chk("t5_grant", 32'(o_grant), 32'd0);
        chk("t5_busy",  32'(o_busy), 32'd0);
        chk("t5_q",     32'(o_quotient), 32'd0);
        chk("t5_r",     32'(o_remainder), 32'd0);
        chk("t5_dd",    32'(o_div_dividend), 32'd0);
        repeat (8) @(negedge i_clock);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        set_op(1, 4'd9, 4'd2);
        i_request = 2'b10;
        wait_done("t5b");
        chk("t5b_done", 32'(o_done), 32'd2);
        chk("t5b_q", 32'(o_quotient), 32'd4);
        chk("t5b_r", 32'(o_remainder), 32'd1);
        i_request = 2'b00;
        @(negedge i_clock);

        // Client0 drops request and changes operands after grant.
        set_op(0, 4'd10, 4'd3);
        i_request = 2'b01;
        @(negedge i_clock);
        chk("t6_grant", 32'(o_grant), 32'd1);
        i_request = 2'b00;
        set_op(0, 4'd15, 4'd1);
        @(negedge i_clock);
        chk("t6_dd_latched", 32'(o_div_dividend), 32'd10);
        wait_done("t6");
        chk("t6_done", 32'(o_done), 32'd1);
        chk("t6_q", 32'(o_quotient), 32'd3);
        chk("t6_r", 32'(o_remainder), 32'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
